// File: rtl/instruction_assembler.sv
// Assembles 16-bit fetch parcels into a decoded instruction (header plus optional address)
// and holds it in an output register that honours the queue's stall back-pressure.
module instruction_assembler #(
    parameter int unsigned ADDR_W = 48
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic [15:0]       parcel_in,
    input  logic              parcel_valid_in,
    output logic              parcel_ready_out,
    input  logic              stall_in,
    output logic              valid_out,
    output logic [3:0]        MajorOpcode_out,
    output logic [4:0]        Source1_out,
    output logic [4:0]        Source2_out,
    output logic [1:0]        OffsetScale_out,
    output logic [4:0]        Destination_out,
    output logic [3:0]        MinorOpcode_out,
    output logic              HasAddress_out,
    output logic [ADDR_W-1:0] Address_out,
    output logic              OffsetSub_out
);

    localparam int unsigned NumAddr = ADDR_W / 16;
    localparam int unsigned CntW    = (NumAddr > 1) ? $clog2(NumAddr) : 1;

    typedef enum logic [1:0] {StHdrHi, StHdrLo, StAddr} state_e;

    state_e              r_state, w_state_next;
    logic [15:0]         r_hdr_hi;
    logic [10:0]         r_hdr_lo;
    logic [CntW-1:0]     r_cnt;
    logic [ADDR_W-1:0]   r_addr;

    logic                r_valid;
    logic [26:0]         r_fields;
    logic [ADDR_W-1:0]   r_address;

    logic                w_out_free, w_last_addr, w_final, w_accept, w_load;
    logic [ADDR_W+15:0]  w_addr_ext;
    logic [26:0]         w_fields;
    logic                w_unused;

    // Header bits [4:0] are reserved; the top of the shifted address falls off the end.
    assign w_unused = ^{parcel_in[4:0], w_addr_ext[ADDR_W+15:ADDR_W]};

    assign w_out_free  = !r_valid || !stall_in;
    assign w_last_addr = (r_cnt == CntW'(NumAddr - 1));
    assign w_final     = ((r_state == StHdrLo) && !parcel_in[6]) ||
                         ((r_state == StAddr) && w_last_addr);

    assign parcel_ready_out = !flush_in && !(w_final && !w_out_free);
    assign w_accept         = parcel_valid_in && parcel_ready_out;
    assign w_load           = w_accept && w_final;

    assign w_addr_ext = {r_addr, parcel_in};
    assign w_fields   = (r_state == StHdrLo) ? {r_hdr_hi, parcel_in[15:5]} : {r_hdr_hi, r_hdr_lo};

    always_comb begin
        w_state_next = r_state;
        if (flush_in) begin
            w_state_next = StHdrHi;
        end else if (w_accept) begin
            unique case (r_state)
                StHdrHi: w_state_next = StHdrLo;
                StHdrLo: w_state_next = parcel_in[6] ? StAddr : StHdrHi;
                StAddr:  w_state_next = w_last_addr ? StHdrHi : StAddr;
                default: w_state_next = StHdrHi;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StHdrHi;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hdr_hi <= '0;
            r_hdr_lo <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
        end else if (flush_in) begin
            r_hdr_hi <= '0;
            r_hdr_lo <= '0;
            r_cnt    <= '0;
            r_addr   <= '0;
        end else if (w_accept) begin
            unique case (r_state)
                StHdrHi: r_hdr_hi <= parcel_in;
                StHdrLo: begin
                    r_hdr_lo <= parcel_in[15:5];
                    r_cnt    <= '0;
                end
                StAddr: begin
                    r_addr <= w_addr_ext[ADDR_W-1:0];
                    r_cnt  <= w_last_addr ? '0 : r_cnt + CntW'(1);
                end
                default: ;
            endcase
        end
    end

    // Flush beats both stall and consume; a load may coincide with a consume (no bubble).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_fields  <= '0;
            r_address <= '0;
        end else if (flush_in) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_fields  <= w_fields;
            r_address <= (r_state == StAddr) ? w_addr_ext[ADDR_W-1:0] : '0;
        end else if (r_valid && !stall_in) begin
            r_valid <= 1'b0;
        end
    end

    assign valid_out       = r_valid;
    assign MajorOpcode_out = r_fields[26:23];
    assign Source1_out     = r_fields[22:18];
    assign Source2_out     = r_fields[17:13];
    assign OffsetScale_out = r_fields[12:11];
    assign Destination_out = r_fields[10:6];
    assign MinorOpcode_out = r_fields[5:2];
    assign HasAddress_out  = r_fields[1];
    assign OffsetSub_out   = r_fields[0];
    assign Address_out     = r_address;

endmodule

// File: tb/tb_instruction_assembler.sv
// Directed bench for instruction_assembler with a short randomized scoreboard run at the end.
module tb_instruction_assembler;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic [15:0] parcel_in;
    logic        parcel_valid_in;
    logic        parcel_ready_out;
    logic        stall_in;
    logic        valid_out;
    logic [3:0]  MajorOpcode_out;
    logic [4:0]  Source1_out;
    logic [4:0]  Source2_out;
    logic [1:0]  OffsetScale_out;
    logic [4:0]  Destination_out;
    logic [3:0]  MinorOpcode_out;
    logic        HasAddress_out;
    logic [47:0] Address_out;
    logic        OffsetSub_out;

    int checks   = 0;
    int failures = 0;

    instruction_assembler #(.ADDR_W(48)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_in         (flush_in),
        .parcel_in        (parcel_in),
        .parcel_valid_in  (parcel_valid_in),
        .parcel_ready_out (parcel_ready_out),
        .stall_in         (stall_in),
        .valid_out        (valid_out),
        .MajorOpcode_out  (MajorOpcode_out),
        .Source1_out      (Source1_out),
        .Source2_out      (Source2_out),
        .OffsetScale_out  (OffsetScale_out),
        .Destination_out  (Destination_out),
        .MinorOpcode_out  (MinorOpcode_out),
        .HasAddress_out   (HasAddress_out),
        .Address_out      (Address_out),
        .OffsetSub_out    (OffsetSub_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] obs_fields();
        return {MajorOpcode_out, Source1_out, Source2_out, OffsetScale_out, Destination_out,
                MinorOpcode_out, HasAddress_out, OffsetSub_out, Address_out};
    endfunction

    task automatic check_fields(input string tag, input logic [3:0] ma, input logic [4:0] s1,
                                input logic [4:0] s2, input logic [1:0] sc, input logic [4:0] de,
                                input logic [3:0] mi, input logic ha, input logic sb,
                                input logic [47:0] ad);
        logic [74:0] exp;
        exp = {ma, s1, s2, sc, de, mi, ha, sb, ad};
        check(tag, 128'(obs_fields()), 128'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] p);
        parcel_valid_in = 1'b1;
        parcel_in       = p;
        #1;
    endtask

    task automatic idle();
        parcel_valid_in = 1'b0;
        #1;
    endtask

    logic [15:0] pq[$];
    logic [74:0] eq[$];
    logic [31:0] hdr;
    logic [47:0] addr;
    logic        has, fire;
    int          got, extra, cyc;

    initial begin
        rst = 1'b1; flush_in = 1'b0; parcel_in = '0; parcel_valid_in = 1'b0; stall_in = 1'b0;
        #2;
        check("rst_valid", 128'(valid_out), 128'(1'b0));
        check("rst_ready", 128'(parcel_ready_out), 128'(1'b1));
        check_fields("rst_fields", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: two-parcel header
        drive(16'h1234);
        check("t1_rdy_hi", 128'(parcel_ready_out), 128'(1'b1));
        step();
        drive(16'h5600);
        check("t1_rdy_lo", 128'(parcel_ready_out), 128'(1'b1));
        check("t1_not_early", 128'(valid_out), 128'(1'b0));
        step();
        idle();
        check("t1_valid", 128'(valid_out), 128'(1'b1));
        check_fields("t1_fields", 1, 4, 13, 0, 10, 12, 0, 0, 0);
        step();
        check("t1_consumed", 128'(valid_out), 128'(1'b0));

        // 2: header plus address, most-significant parcel first
        drive(16'h0000); step();
        drive(16'h0040); step();
        drive(16'hDEAD); step();
        drive(16'hBEEF); step();
        drive(16'hCAFE);
        check("t2_not_early", 128'(valid_out), 128'(1'b0));
        step();
        idle();
        check("t2_valid", 128'(valid_out), 128'(1'b1));
        check_fields("t2_fields", 0, 0, 0, 0, 0, 0, 1, 0, 48'hDEADBEEFCAFE);
        step();
        check("t2_consumed", 128'(valid_out), 128'(1'b0));

        // 3: stall blocks only the final parcel; release loads with no bubble
        stall_in = 1'b1;
        drive(16'h1234); step();
        drive(16'h5600);
        check("t3_rdy_free", 128'(parcel_ready_out), 128'(1'b1));
        step();
        drive(16'hFFFF);
        check("t3_valid", 128'(valid_out), 128'(1'b1));
        check("t3_rdy_nonfinal", 128'(parcel_ready_out), 128'(1'b1));
        step();
        drive(16'h0000);
        check("t3_rdy_blocked", 128'(parcel_ready_out), 128'(1'b0));
        step();
        check("t3_hold_valid", 128'(valid_out), 128'(1'b1));
        check_fields("t3_hold_fields", 1, 4, 13, 0, 10, 12, 0, 0, 0);
        stall_in = 1'b0;
        #1;
        check("t3_rdy_release", 128'(parcel_ready_out), 128'(1'b1));
        step();
        check("t3_no_bubble", 128'(valid_out), 128'(1'b1));
        check_fields("t3_fields", 15, 31, 31, 3, 0, 0, 0, 0, 0);

        // 4: partial address instruction then flush, while an output is stalled
        stall_in = 1'b1;
        drive(16'h0000); step();
        drive(16'h0040); step();
        drive(16'hDEAD); step();
        check_fields("t4_hold_fields", 15, 31, 31, 3, 0, 0, 0, 0, 0);
        flush_in = 1'b1;
        drive(16'hBEEF);
        check("t4_rdy_flush", 128'(parcel_ready_out), 128'(1'b0));
        step();
        flush_in = 1'b0;
        stall_in = 1'b0;
        idle();
        check("t4_flushed", 128'(valid_out), 128'(1'b0));
        drive(16'hABCD); step();
        drive(16'h1234); step();
        idle();
        check("t4_valid", 128'(valid_out), 128'(1'b1));
        check_fields("t4_fields", 10, 23, 19, 1, 2, 4, 0, 1, 0);
        step();

        // 5: asynchronous reset mid-stream
        stall_in = 1'b1;
        drive(16'h1234); step();
        drive(16'h5600); step();
        drive(16'h7000); step();
        idle();
        check("t5_pre_valid", 128'(valid_out), 128'(1'b1));
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 128'(valid_out), 128'(1'b0));
        check("t5_rst_ready", 128'(parcel_ready_out), 128'(1'b1));
        check_fields("t5_rst_fields", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        stall_in = 1'b0;
        #1;
        drive(16'h2000); step();
        drive(16'h0000); step();
        idle();
        check("t5_valid", 128'(valid_out), 128'(1'b1));
        check_fields("t5_fields", 2, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // 6: random gaps and stalls against an in-order scoreboard
        for (int i = 0; i < 300; i++) begin
            hdr        = $urandom;
            has        = 1'($urandom_range(0, 1));
            hdr[6]     = has;
            addr[47:32] = 16'($urandom);
            addr[31:0]  = $urandom;
            pq.push_back(hdr[31:16]);
            pq.push_back(hdr[15:0]);
            if (has) begin
                pq.push_back(addr[47:32]);
                pq.push_back(addr[31:16]);
                pq.push_back(addr[15:0]);
            end
            eq.push_back({hdr[31:5], has ? addr : 48'h0});
        end
        got = 0; extra = 0; cyc = 0;
        while (got < 300 && cyc < 20000) begin
            stall_in        = ($urandom_range(0, 3) == 0);
            parcel_valid_in = (pq.size() > 0) && ($urandom_range(0, 3) != 0);
            parcel_in       = (pq.size() > 0) ? pq[0] : 16'h0;
            #1;
            if (valid_out && !stall_in) begin
                if (eq.size() == 0) begin
                    extra++;
                end else begin
                    check("t6_instr", 128'(obs_fields()), 128'(eq.pop_front()));
                    got++;
                end
            end
            fire = parcel_valid_in && parcel_ready_out;
            step();
            if (fire) void'(pq.pop_front());
            cyc++;
        end
        check("t6_count", 128'(got), 128'(300));
        check("t6_no_extra", 128'(extra), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
